process_gyro: RTL and testbench

- Integrates three signed gyroscope rate readings (gx, gy, gz) into absolute angles in whole degrees, 0..359.
- Axis mapping: gx -> pitch, gy -> roll, gz -> yaw.
- Sits between the IMU reader (which supplies raw 16-bit rate words) and orientation consumers such as display and control logic.
- Integration runs on a fixed sample strobe derived from the 100 MHz system clock.

---
 rtl/gyro_pkg.sv | 10 +
 rtl/gyro_axis_integrator.sv | 39 +++
 rtl/process_gyro.sv | 42 ++++
 tb/tb_process_gyro.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/gyro_pkg.sv
// rtl/gyro_pkg.sv - shared widths, limits and types for the gyro angle integrator
package gyro_pkg;
   localparam int ANGLE_W   = 9;
   localparam int ANGLE_MAX = 359;
   localparam int RATE_W    = 16;
   localparam int RES_W     = 32;

   typedef logic [ANGLE_W-1:0]       angle_t;
   typedef logic signed [RATE_W-1:0] rate_t;
endpackage

// File: rtl/gyro_axis_integrator.sv
// rtl/gyro_axis_integrator.sv - one axis: accumulates rate into a residual, steps a 0..359 angle
module gyro_axis_integrator
   import gyro_pkg::*;
#(
   parameter int DEG_COUNTS = 131_000
) (
   input  logic   clk,
   input  logic   rst_in,
   input  logic   strobe,
   input  rate_t  rate,
   output angle_t angle
);
   localparam logic signed [RES_W-1:0] DEG_POS = RES_W'(DEG_COUNTS);
   localparam logic signed [RES_W-1:0] DEG_NEG = -DEG_POS;
   localparam angle_t                  A_MAX   = ANGLE_W'(ANGLE_MAX);

   logic signed [RES_W-1:0] residual;
   logic signed [RES_W-1:0] sum;

   assign sum = residual + RES_W'(rate);

   // Residual keeps the sub-degree remainder so slow rates still integrate exactly.
   always_ff @(posedge clk) begin
      if (!rst_in) begin
         residual <= '0;
         angle    <= '0;
      end else if (strobe) begin
         if (sum >= DEG_POS) begin
            residual <= sum - DEG_POS;
            angle    <= (angle == A_MAX) ? '0 : angle + 1'b1;
         end else if (sum <= DEG_NEG) begin
            residual <= sum + DEG_POS;
            angle    <= (angle == '0) ? A_MAX : angle - 1'b1;
         end else begin
            residual <= sum;
         end
      end
   end
endmodule

// File: rtl/process_gyro.sv
// rtl/process_gyro.sv - sample strobe generator feeding three independent axis integrators
module process_gyro
   import gyro_pkg::*;
#(
   parameter int SAMPLE_CYCLES = 100_000,
   parameter int DEG_COUNTS    = 131_000
) (
   input  logic        clk_100mhz,
   input  logic        rst_in,
   input  logic [15:0] gx,
   input  logic [15:0] gy,
   input  logic [15:0] gz,
   output logic [8:0]  pitch,
   output logic [8:0]  roll,
   output logic [8:0]  yaw
);
   localparam int CNT_W = $clog2(SAMPLE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_CYCLES - 1);

   logic [CNT_W-1:0] counter;
   logic             strobe;

   assign strobe = (counter == CNT_LAST);

   always_ff @(posedge clk_100mhz) begin
      if (!rst_in)     counter <= '0;
      else if (strobe) counter <= '0;
      else             counter <= counter + 1'b1;
   end

   gyro_axis_integrator #(.DEG_COUNTS(DEG_COUNTS)) u_pitch (
      .clk(clk_100mhz), .rst_in(rst_in), .strobe(strobe), .rate(rate_t'(gx)), .angle(pitch)
   );

   gyro_axis_integrator #(.DEG_COUNTS(DEG_COUNTS)) u_roll (
      .clk(clk_100mhz), .rst_in(rst_in), .strobe(strobe), .rate(rate_t'(gy)), .angle(roll)
   );

   gyro_axis_integrator #(.DEG_COUNTS(DEG_COUNTS)) u_yaw (
      .clk(clk_100mhz), .rst_in(rst_in), .strobe(strobe), .rate(rate_t'(gz)), .angle(yaw)
   );
endmodule

// File: tb/tb_process_gyro.sv
// tb/tb_process_gyro.sv - scoreboard bench for process_gyro with shortened sample period
module tb_process_gyro;
   localparam int SC = 10;
   localparam int DC = 1000;

   logic        clk_100mhz = 1'b0;
   logic        rst_in = 1'b0;
   logic [15:0] gx = '0, gy = '0, gz = '0;
   logic [8:0]  pitch, roll, yaw;

   typedef struct { int p; int r; int y; } exp_t;
   exp_t exp_q[$];

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int m_res[3];
   int m_ang[3];

   process_gyro #(.SAMPLE_CYCLES(SC), .DEG_COUNTS(DC)) dut (
      .clk_100mhz(clk_100mhz), .rst_in(rst_in),
      .gx(gx), .gy(gy), .gz(gz),
      .pitch(pitch), .roll(roll), .yaw(yaw)
   );

   always #5 clk_100mhz = ~clk_100mhz;

   task automatic check(input string tag, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   // Reference: plain integer arithmetic, degrees kept modulo 360.
   task automatic model_axis(input int i, input int rate);
      int s;
      s = m_res[i] + rate;
      if (s >= DC) begin
         m_res[i] = s - DC;
         m_ang[i] = (m_ang[i] + 1) % 360;
      end else if (s <= -DC) begin
         m_res[i] = s + DC;
         m_ang[i] = (m_ang[i] + 359) % 360;
      end else begin
         m_res[i] = s;
      end
   endtask

   task automatic tick();
      exp_t e;
      @(posedge clk_100mhz);
      #1;
      if (!rst_in) begin
         cyc = 0;
         for (int i = 0; i < 3; i++) begin m_res[i] = 0; m_ang[i] = 0; end
         exp_q.push_back('{0, 0, 0});
      end else begin
         cyc++;
         if (cyc % SC == 0) begin
            model_axis(0, int'($signed(gx)));
            model_axis(1, int'($signed(gy)));
            model_axis(2, int'($signed(gz)));
            exp_q.push_back('{m_ang[0], m_ang[1], m_ang[2]});
         end else if (cyc % SC == SC / 2) begin
            exp_q.push_back('{m_ang[0], m_ang[1], m_ang[2]});
         end
      end
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check("sb_pitch", int'(pitch), e.p);
         check("sb_roll", int'(roll), e.r);
         check("sb_yaw", int'(yaw), e.y);
      end
   endtask

   task automatic run(input int n);
      repeat (n) tick();
   endtask

   task automatic do_reset(input int n);
      rst_in = 1'b0;
      run(n);
      rst_in = 1'b1;
   endtask

   initial begin
      // Reset with nonzero rates, then confirm no step before the first strobe.
      gx = 16'd1; gy = 16'd1; gz = 16'd1;
      do_reset(2);
      check("rst_pitch", int'(pitch), 0);
      check("rst_roll", int'(roll), 0);
      check("rst_yaw", int'(yaw), 0);
      run(SC - 1);
      check("pre_strobe_pitch", int'(pitch), 0);

      // Opposite rates on pitch and yaw, zero on roll.
      do_reset(1);
      gx = 16'd256; gy = 16'd0; gz = -16'sd256;
      run(3 * SC);
      check("s3_pitch", int'(pitch), 0);
      run(SC);
      check("s4_pitch", int'(pitch), 1);
      check("s4_roll", int'(roll), 0);
      check("s4_yaw", int'(yaw), 359);
      run(4 * SC);
      check("s8_pitch", int'(pitch), 2);
      check("s8_yaw", int'(yaw), 358);

      // Exact-threshold rates: one step per strobe, wrapping both directions.
      do_reset(1);
      gx = 16'd1000; gy = -16'sd1000; gz = 16'd500;
      run(359 * SC);
      check("wrap359_pitch", int'(pitch), 359);
      check("wrap359_roll", int'(roll), 1);
      run(SC);
      check("wrap360_pitch", int'(pitch), 0);
      check("wrap360_roll", int'(roll), 0);
      check("wrap360_yaw", int'(yaw), 180);
      run(SC);
      check("wrap361_pitch", int'(pitch), 1);
      run(122 * SC + 4);
      check("mid_pitch", int'(pitch), 123);

      // Mid-interval reset for a single edge, then a slower rate.
      do_reset(1);
      check("midrst_pitch", int'(pitch), 0);
      gx = 16'd100; gy = 16'd0; gz = 16'd0;
      run(9 * SC);
      check("post9_pitch", int'(pitch), 0);
      run(SC);
      check("post10_pitch", int'(pitch), 1);

      // Sign change cancels the residual; inputs wiggled between strobes are ignored.
      do_reset(1);
      gx = 16'd600;
      run(SC);
      gx = -16'sd600;
      run(SC / 2);
      gx = 16'h7fff;
      run(SC / 2 - 1);
      gx = -16'sd600;
      run(1);
      check("sign_pitch", int'(pitch), 0);
      gx = 16'd999;
      run(SC);
      check("resid_clear_pitch", int'(pitch), 0);
      gx = 16'd1;
      run(SC);
      check("resid_full_pitch", int'(pitch), 1);
      gx = 16'd0;
      run(5 * SC);
      check("zero_hold_pitch", int'(pitch), 1);
      check("queue_drained", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
